// File: rtl/ks_sub_pipe_32.sv
// Kogge-Stone subtractor: Y = A - B - BIN, computed as A + ~B + ~BIN.
// The pipeline has three register stages with a valid/ready handshake.
// S1 holds the init generate/propagate terms. S2 holds the first half of the
// prefix levels. S3 holds the difference and the BOUT/OVF/ZERO flags.
module ks_sub_pipe_32 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Y,
  output logic             BOUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int L = $clog2(WIDTH);
  localparam int H = (L + 1) / 2;

  // One Kogge-Stone prefix level at the given span; bits below span pass through
  function automatic logic [2*WIDTH-1:0] ks_level(
    input logic [WIDTH-1:0] g,
    input logic [WIDTH-1:0] p,
    input int               span
  );
    logic [WIDTH-1:0] g_o;
    logic [WIDTH-1:0] p_o;
    g_o = g;
    p_o = p;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= span) begin
        g_o[i] = g[i] | (p[i] & g[i-span]);
        p_o[i] = p[i] & p[i-span];
      end
    end
    return {g_o, p_o};
  endfunction

  logic             adv;

  logic             vld_p1;
  logic [WIDTH-1:0] g_p1;
  logic [WIDTH-1:0] p_p1;
  logic             cin_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] g_p2;
  logic [WIDTH-1:0] p_p2;
  logic [WIDTH-1:0] p_init_p2;
  logic             cin_p2;

  logic             vld_p3;
  logic [WIDTH-1:0] y_p3;
  logic             bout_p3;
  logic             ovf_p3;
  logic             zero_p3;

  logic [WIDTH-1:0] g_s2;
  logic [WIDTH-1:0] p_s2;
  logic [WIDTH-1:0] g_s3;
  logic [WIDTH-1:0] p_s3;
  logic [WIDTH:0]   carry_s3;
  logic [WIDTH-1:0] y_s3;
  logic             bout_s3;
  logic             ovf_s3;
  logic             zero_s3;

  // All stages move together; the pipe stalls only when a held result is not taken
  assign adv      = ~vld_p3 | OUT_READY;
  assign IN_READY = adv;

  // ---- stage 1: init cells (G = A & ~B, P = A ^ ~B) and inverted borrow-in ----
  // Capture the init generate/propagate terms and the carry-in for a valid operand set
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1 <= 1'b0;
      g_p1   <= '0;
      p_p1   <= '0;
      cin_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= IN_VALID;
      if (IN_VALID) begin
        g_p1   <= A & ~B;
        p_p1   <= A ^ ~B;
        cin_p1 <= ~BIN;
      end
    end
  end

  // ---- stage 2: prefix levels 1..H ----
  // Apply the lower prefix levels at spans 1, 2, 4, ... up to level H
  always_comb begin
    g_s2 = g_p1;
    p_s2 = p_p1;
    for (int lv = 0; lv < H; lv++) begin
      {g_s2, p_s2} = ks_level(g_s2, p_s2, 1 << lv);
    end
  end

  // Register the half-resolved prefix terms and keep the init propagate for the sum
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p2    <= 1'b0;
      g_p2      <= '0;
      p_p2      <= '0;
      p_init_p2 <= '0;
      cin_p2    <= 1'b0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        g_p2      <= g_s2;
        p_p2      <= p_s2;
        p_init_p2 <= p_p1;
        cin_p2    <= cin_p1;
      end
    end
  end

  // ---- stage 3: remaining prefix levels, carries, sum and flags ----
  // Finish the prefix tree, fold in the carry-in, and form the difference and flags
  always_comb begin
    g_s3 = g_p2;
    p_s3 = p_p2;
    for (int lv = H; lv < L; lv++) begin
      {g_s3, p_s3} = ks_level(g_s3, p_s3, 1 << lv);
    end
    carry_s3 = {g_s3 | (p_s3 & {WIDTH{cin_p2}}), cin_p2};
    y_s3     = p_init_p2 ^ carry_s3[WIDTH-1:0];
    bout_s3  = ~carry_s3[WIDTH];
    ovf_s3   = carry_s3[WIDTH] ^ carry_s3[WIDTH-1];
    zero_s3  = ~|y_s3;
  end

  // Output register; it holds its result while the consumer stalls
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p3  <= 1'b0;
      y_p3    <= '0;
      bout_p3 <= 1'b0;
      ovf_p3  <= 1'b0;
      zero_p3 <= 1'b0;
    end else if (adv) begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        y_p3    <= y_s3;
        bout_p3 <= bout_s3;
        ovf_p3  <= ovf_s3;
        zero_p3 <= zero_s3;
      end
    end
  end

  assign Y         = y_p3;
  assign BOUT      = bout_p3;
  assign OVF       = ovf_p3;
  assign ZERO      = zero_p3;
  assign OUT_VALID = vld_p3;

endmodule

// File: tb/tb_ks_sub_pipe_32.sv
// Self-checking bench for ks_sub_pipe_32 (WIDTH=32) with an arithmetic reference model.
module tb_ks_sub_pipe_32;

  typedef struct packed {
    logic [31:0] y;
    logic        bout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] A;
  logic [31:0] B;
  logic        BIN;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] Y;
  logic        BOUT;
  logic        OVF;
  logic        ZERO;
  logic        OUT_VALID;
  logic        OUT_READY;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];

  ks_sub_pipe_32 #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .A        (A),
    .B        (B),
    .BIN      (BIN),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .Y        (Y),
    .BOUT     (BOUT),
    .OVF      (OVF),
    .ZERO     (ZERO),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  // Reference: plain 64-bit integer subtraction
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    res_t   r;
    longint ud;
    longint sd;
    ud     = longint'({32'b0, a}) - longint'({32'b0, b}) - longint'({63'b0, bin});
    sd     = longint'($signed(a)) - longint'($signed(b)) - longint'({63'b0, bin});
    r.y    = ud[31:0];
    r.bout = (ud < 0);
    r.ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    r.zero = (r.y == 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // One clock of stimulus: drive on the falling edge, observe 1 time unit later.
  // The handshakes seen then are the ones the next rising edge acts on.
  task automatic drive_cycle(input logic [31:0] a, input logic [31:0] b, input logic bin,
                             input logic iv, input logic ordy,
                             output logic fire, output logic ov, output logic ir,
                             output res_t got);
    @(negedge CLK);
    A = a; B = b; BIN = bin; IN_VALID = iv; OUT_READY = ordy;
    #1;
    ir   = IN_READY;
    ov   = OUT_VALID;
    fire = OUT_VALID && ordy;
    got  = {Y, BOUT, OVF, ZERO};
    if (iv && IN_READY) exp_q.push_back(model(a, b, bin));
  endtask

  task automatic test_reset();
    RST_N = 1'b1; A = '0; B = '0; BIN = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
    checks++;
    if ({Y, BOUT, OVF, ZERO} !== 35'h0) begin
      errors++; $display("FAIL reset_outputs: got Y=%h BOUT=%b OVF=%b ZERO=%b expected all 0", Y, BOUT, OVF, ZERO);
    end
    checks++;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL after_reset: got IN_READY=%b OUT_VALID=%b expected 1/0", IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[5];
    logic [31:0] tb[5];
    logic        tbin[5];
    res_t        tr[5];
    logic        fire, ov, ir, seen;
    res_t        got, m;
    ta   = '{32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h1234_5678};
    tb   = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h1234_5678};
    tbin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tr[0] = {32'h0000_0002, 1'b0, 1'b0, 1'b0};
    tr[1] = {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tr[2] = {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tr[3] = {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    tr[4] = {32'h0000_0000, 1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 5; v++) begin
      seen = 1'b0;
      drive_cycle(ta[v], tb[v], tbin[v], 1'b1, 1'b1, fire, ov, ir, got);
      for (int k = 1; k <= 8 && !seen; k++) begin
        drive_cycle('0, '0, 1'b0, 1'b0, 1'b1, fire, ov, ir, got);
        if (fire) begin
          seen = 1'b1;
          m = exp_q.pop_front();
          checks++;
          if (k != 3) begin errors++; $display("FAIL directed%0d_latency: got %0d expected 3", v, k); end
          checks++;
          if (got !== tr[v]) begin errors++; $display("FAIL directed%0d_result: got %h expected %h", v, got, tr[v]); end
          checks++;
          if (got !== m) begin errors++; $display("FAIL directed%0d_model: got %h expected %h", v, got, m); end
        end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL directed%0d_timeout: got no OUT_VALID expected a result", v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   acc, got_n;
    logic fire, ov, ir, iv, ordy;
    res_t got, held, m;
    acc = 0; got_n = 0; held = '0;
    for (int c = 0; c < 40 && got_n < 8; c++) begin
      ordy = !(c >= 4 && c <= 6);
      iv   = (acc < 8);
      drive_cycle(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), iv, ordy, fire, ov, ir, got);
      if (iv && ir) acc++;
      if (c >= 4 && c <= 6) begin
        checks++;
        if (ir !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_c%0d: got %b expected 0", c, ir); end
      end
      if (c == 4) held = got;
      if (c == 5 || c == 6) begin
        checks++;
        if (ov !== 1'b1 || got !== held) begin
          errors++; $display("FAIL b2b_hold_c%0d: got valid=%b %h expected valid=1 %h", c, ov, got, held);
        end
      end
      if (fire) begin
        got_n++;
        m = exp_q.pop_front();
        checks++;
        if (got !== m) begin errors++; $display("FAIL b2b_result%0d: got %h expected %h", got_n, got, m); end
      end
    end
    checks++;
    if (got_n != 8 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: got %0d results (%0d pending) expected 8", got_n, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic fire, ov, ir, seen;
    res_t got, m;
    int   stray;
    drive_cycle(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 1'b1, fire, ov, ir, got);
    drive_cycle(32'h0000_0020, 32'h0000_0002, 1'b0, 1'b1, 1'b1, fire, ov, ir, got);
    drive_cycle(32'h0000_0030, 32'h0000_0003, 1'b0, 1'b1, 1'b1, fire, ov, ir, got);
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || {Y, BOUT, OVF, ZERO} !== 35'h0) begin
      errors++; $display("FAIL midreset_clear: got valid=%b Y=%h expected valid=0 Y=0", OUT_VALID, Y);
    end
    checks++;
    if (IN_READY !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", IN_READY); end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1; IN_VALID = 1'b0;
    exp_q.delete();
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      drive_cycle('0, '0, 1'b0, 1'b0, 1'b1, fire, ov, ir, got);
      if (ov) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL midreset_stale: got %0d valid cycles expected 0", stray); end
    seen = 1'b0;
    drive_cycle(32'h0000_0100, 32'h0000_0001, 1'b1, 1'b1, 1'b1, fire, ov, ir, got);
    for (int k = 1; k <= 8 && !seen; k++) begin
      drive_cycle('0, '0, 1'b0, 1'b0, 1'b1, fire, ov, ir, got);
      if (fire) begin
        seen = 1'b1;
        m = exp_q.pop_front();
        checks++;
        if (k != 3) begin errors++; $display("FAIL midreset_latency: got %0d expected 3", k); end
        checks++;
        if (got.y !== 32'h0000_00FE || got !== m) begin
          errors++; $display("FAIL midreset_result: got %h expected %h", got, m);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL midreset_timeout: got no OUT_VALID expected a result");
    end
  endtask

  task automatic test_random();
    logic fire, ov, ir, iv, ordy, prev_stall;
    res_t got, prev_got, m;
    int   in_pct, out_pct;
    prev_stall = 1'b0; prev_got = '0;
    for (int c = 0; c < 20000; c++) begin
      if (c % 1000 == 0) begin
        in_pct  = $urandom_range(20, 100);
        out_pct = $urandom_range(20, 100);
      end
      iv   = ($urandom_range(1, 100) <= in_pct);
      ordy = ($urandom_range(1, 100) <= out_pct);
      drive_cycle(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), iv, ordy, fire, ov, ir, got);
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || got !== prev_got) begin
          errors++; $display("FAIL rand_hold_c%0d: got valid=%b %h expected valid=1 %h", c, ov, got, prev_got);
        end
      end
      prev_stall = ov && !ordy;
      prev_got   = got;
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_c%0d: got %h expected no result", c, got);
        end else begin
          m = exp_q.pop_front();
          if (got !== m) begin errors++; $display("FAIL rand_result_c%0d: got %h expected %h", c, got, m); end
        end
      end
    end
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      drive_cycle('0, '0, 1'b0, 1'b0, 1'b1, fire, ov, ir, got);
      if (fire) begin
        m = exp_q.pop_front();
        checks++;
        if (got !== m) begin errors++; $display("FAIL rand_drain: got %h expected %h", got, m); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
